// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared op codes, FSM state encodings and constants for the HI/LO multiply/divide controller.
package hilo_mdu_ctrl_pkg;

  localparam int OP_W = 3;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic is_muldiv(input logic [2:0] code);
    return (code >= OP_MULT) && (code <= OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_div_iter.sv
// Restoring shift-subtract divider datapath on unsigned magnitudes, one quotient bit per step.
// quot/rem present the values that result from the step taken this cycle.
module mdu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] q_reg;
  logic [XLEN-1:0] r_reg;
  logic [XLEN-1:0] d_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted = {r_reg, q_reg[XLEN-1]};
    diff    = shifted - {1'b0, d_reg};
    fits    = shifted >= {1'b0, d_reg};
    if (fits) begin
      rem = diff[XLEN-1:0];
    end else begin
      rem = shifted[XLEN-1:0];
    end
    quot = {q_reg[XLEN-2:0], fits};
  end

  // Working registers: quotient shifts in from the dividend, remainder restores on failure.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
      r_reg <= '0;
      d_reg <= '0;
    end else if (load) begin
      q_reg <= dividend;
      r_reg <= '0;
      d_reg <= divisor;
    end else if (step) begin
      q_reg <= quot;
      r_reg <= rem;
    end else begin
      q_reg <= q_reg;
      r_reg <= r_reg;
    end
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO write sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO with iterative multiply/divide.
// Optional HILO_MDU_FAST_MUL_EN: single-cycle combinational multiply instead of the 32-step one.
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ITER_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic [XLEN-1:0] hi_rdata,
  input  logic [XLEN-1:0] lo_rdata,
  output logic            stall,
  output logic            hilo_we,
  output logic [XLEN-1:0] hilo_hi_wdata,
  output logic [XLEN-1:0] hilo_lo_wdata
);

  logic [1:0]        state;
  logic [ITER_W-1:0] count;
  logic              neg_lo;
  logic              neg_hi;
  logic              div_zero;
  logic [XLEN-1:0]   raw_a;
`ifdef HILO_MDU_FAST_MUL_EN
  logic [XLEN-1:0]          raw_b;
  logic                     sgn;
  logic signed [2*XLEN+1:0] prod_full;
`else
  logic [XLEN-1:0]   mag_a;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN:0]     acc_sum;
`endif

  logic              idle;
  logic              accept;
  logic              start_div;
  logic              last;
  logic              is_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a_in;
  logic [XLEN-1:0]   mag_b_in;
  logic [XLEN-1:0]   cur_hi;
  logic [XLEN-1:0]   cur_lo;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [2*XLEN-1:0] mul_res;
  logic [XLEN-1:0]   div_hi;
  logic [XLEN-1:0]   div_lo;

  assign idle      = (state == ST_IDLE);
  assign accept    = idle & op_valid & ~flush & (op != OP_NOP) & (op <= OP_MTLO);
  assign start_div = accept & ((op == OP_DIV) | (op == OP_DIVU));
  assign last      = (count == ITER_W'(XLEN - 1));
  assign is_sgn    = is_signed_op(op);
  assign a_neg     = is_sgn & src_a[XLEN-1];
  assign b_neg     = is_sgn & src_b[XLEN-1];
  assign mag_a_in  = a_neg ? -src_a : src_a;
  assign mag_b_in  = b_neg ? -src_b : src_b;

  // A pending write is newer than the register contents, so MT ops merge against it.
  assign cur_hi = hilo_we ? hilo_hi_wdata : hi_rdata;
  assign cur_lo = hilo_we ? hilo_lo_wdata : lo_rdata;

`ifdef HILO_MDU_FAST_MUL_EN
  assign stall = (idle & op_valid & ~flush & is_muldiv(op))
               | ((state == ST_DIV) & ~last & ~flush);
`else
  assign stall = (idle & op_valid & ~flush & is_muldiv(op))
               | (((state == ST_MUL) | (state == ST_DIV)) & ~last & ~flush);
`endif

  mdu_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (start_div),
    .step     (state == ST_DIV),
    .dividend (mag_a_in),
    .divisor  (mag_b_in),
    .quot     (quot),
    .rem      (rem)
  );

`ifdef HILO_MDU_FAST_MUL_EN
  // Sign- or zero-extend to 33 bits so one signed multiplier serves both MULT and MULTU.
  always_comb begin
    prod_full = $signed({sgn & raw_a[XLEN-1], raw_a}) * $signed({sgn & raw_b[XLEN-1], raw_b});
    mul_res   = prod_full[2*XLEN-1:0];
  end
`else
  // Shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
  always_comb begin
    acc_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_a};
    if (acc[0]) begin
      acc_next = {acc_sum, acc[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*XLEN-1:1]};
    end
    if (neg_lo) begin
      mul_res = -acc_next;
    end else begin
      mul_res = acc_next;
    end
  end
`endif

  // Divide-by-zero returns the original dividend in HI and all-ones in LO.
  always_comb begin
    if (div_zero) begin
      div_hi = raw_a;
      div_lo = XLEN'(DIV0_LO);
    end else begin
      div_hi = neg_hi ? -rem : rem;
      div_lo = neg_lo ? -quot : quot;
    end
  end

  // Control FSM and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= '0;
      hilo_we       <= 1'b0;
      hilo_hi_wdata <= '0;
      hilo_lo_wdata <= '0;
      neg_lo        <= 1'b0;
      neg_hi        <= 1'b0;
      div_zero      <= 1'b0;
      raw_a         <= '0;
`ifdef HILO_MDU_FAST_MUL_EN
      raw_b         <= '0;
      sgn           <= 1'b0;
`else
      mag_a         <= '0;
      acc           <= '0;
`endif
    end else begin
      hilo_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: begin
                hilo_we       <= 1'b1;
                hilo_hi_wdata <= src_a;
                hilo_lo_wdata <= cur_lo;
              end
              OP_MTLO: begin
                hilo_we       <= 1'b1;
                hilo_hi_wdata <= cur_hi;
                hilo_lo_wdata <= src_a;
              end
              default: begin
                state    <= start_div ? ST_DIV : ST_MUL;
                count    <= '0;
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= a_neg;
                div_zero <= (src_b == '0);
                raw_a    <= src_a;
`ifdef HILO_MDU_FAST_MUL_EN
                raw_b    <= src_b;
                sgn      <= is_sgn;
`else
                mag_a    <= mag_a_in;
                acc      <= {{XLEN{1'b0}}, mag_b_in};
`endif
              end
            endcase
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
            count <= '0;
`ifdef HILO_MDU_FAST_MUL_EN
          end else begin
            state                          <= ST_IDLE;
            hilo_we                        <= 1'b1;
            {hilo_hi_wdata, hilo_lo_wdata} <= mul_res;
          end
`else
          end else if (last) begin
            state                          <= ST_IDLE;
            count                          <= '0;
            hilo_we                        <= 1'b1;
            {hilo_hi_wdata, hilo_lo_wdata} <= mul_res;
          end else begin
            count <= count + ITER_W'(1);
            acc   <= acc_next;
          end
`endif
        end
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (last) begin
            state         <= ST_IDLE;
            count         <= '0;
            hilo_we       <= 1'b1;
            hilo_hi_wdata <= div_hi;
            hilo_lo_wdata <= div_lo;
          end else begin
            count <= count + ITER_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Randomized self-checking bench for hilo_mdu_ctrl against an arithmetic reference model.
module tb_hilo_mdu_ctrl;
  import hilo_mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] hi_reg = 32'd0;
  logic [31:0] lo_reg = 32'd0;
  logic        stall;
  logic        hilo_we;
  logic [31:0] hilo_hi_wdata;
  logic [31:0] hilo_lo_wdata;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  hilo_mdu_ctrl #(.XLEN(32), .ITER_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .op            (op),
    .src_a         (src_a),
    .src_b         (src_b),
    .flush         (flush),
    .hi_rdata      (hi_reg),
    .lo_rdata      (lo_reg),
    .stall         (stall),
    .hilo_we       (hilo_we),
    .hilo_hi_wdata (hilo_hi_wdata),
    .hilo_lo_wdata (hilo_lo_wdata)
  );

  always #5 clk = ~clk;

  // Cycle counter plus the external hilo register the block writes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (hilo_we) begin
      hi_reg <= hilo_hi_wdata;
      lo_reg <= hilo_lo_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference: architectural result of one op from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_MTHI:  res = {a, lo_m};
      OP_MTLO:  res = {hi_m, a};
      default:  res = {hi_m, lo_m};
    endcase
    return res;
  endfunction

  // Every cycle: a write must appear exactly when the scoreboard says, nowhere else.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("we_pulse", {63'd0, hilo_we}, 64'd1);
      check("wr_hi", {32'd0, hilo_hi_wdata}, {32'd0, e.hi});
      check("wr_lo", {32'd0, hilo_lo_wdata}, {32'd0, e.lo});
    end else begin
      check("we_quiet", {63'd0, hilo_we}, 64'd0);
    end
  end

  task automatic push_exp(input int at, input logic [63:0] res);
    exp_t e;
    e.cyc = at;
    e.hi  = res[63:32];
    e.lo  = res[31:0];
    exp_q.push_back(e);
    hi_m = res[63:32];
    lo_m = res[31:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      op_valid = 1'b0;
      flush    = 1'b0;
      #1;
      check("idle_stall", {63'd0, stall}, 64'd0);
    end
  endtask

  // Issue one op in cycle 0; kill_at>0 injects flush (or rst) at that busy cycle.
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int kill_at, input bit kill_rst);
    int n_busy;
    logic [63:0] res;
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    flush    = 1'b0;
    #1;
    res = ref_op(o, a, b);
    if (o == OP_MTHI || o == OP_MTLO) begin
      check("mt_stall", {63'd0, stall}, 64'd0);
      push_exp(cyc + 1, res);
      return;
    end
    if (o < OP_MULT || o > OP_DIVU) begin
      check("nop_stall", {63'd0, stall}, 64'd0);
      return;
    end
    check("acc_stall", {63'd0, stall}, 64'd1);
    n_busy = 32;
`ifdef HILO_MDU_FAST_MUL_EN
    if (o == OP_MULT || o == OP_MULTU) n_busy = 1;
`endif
    for (int k = 1; k <= n_busy; k++) begin
      @(negedge clk);
      op_valid = 1'($urandom_range(0, 1));
      op       = 3'($urandom);
      src_a    = $urandom;
      src_b    = $urandom;
      if (k == kill_at && kill_rst) begin
        rst      = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_we", {63'd0, hilo_we}, 64'd0);
        check("rst_hi", {32'd0, hilo_hi_wdata}, 64'd0);
        check("rst_lo", {32'd0, hilo_lo_wdata}, 64'd0);
        return;
      end
      if (k == kill_at) begin
        flush = 1'b1;
        #1;
        check("flush_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        op_valid = 1'b0;
        #1;
        check("post_flush_stall", {63'd0, stall}, 64'd0);
        return;
      end
      #1;
      check("busy_stall", {63'd0, stall}, {63'd0, (k < n_busy)});
    end
    push_exp(cyc + 1, res);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] ro;
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_we", {63'd0, hilo_we}, 64'd0);
    check("reset_wdata", {hilo_hi_wdata, hilo_lo_wdata}, 64'd0);
    rst = 1'b0;

    send(OP_MTHI, 32'h1111_1111, 32'd0, 0, 1'b0);
    send(OP_MTLO, 32'h2222_2222, 32'd0, 0, 1'b0);
    idle(2);
    check("plan_mt", {hi_reg, lo_reg}, 64'h1111_1111_2222_2222);

    send(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
    idle(2);
    check("plan_mult", {hi_reg, lo_reg}, 64'hFFFF_FFFF_FFFF_FFFA);
    send(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
    idle(2);
    check("plan_multu", {hi_reg, lo_reg}, 64'h0000_0002_FFFF_FFFA);
    send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    idle(2);
    check("plan_div", {hi_reg, lo_reg}, 64'hFFFF_FFFF_FFFF_FFFD);
    send(OP_DIVU, 32'h8000_0000, 32'd3, 0, 1'b0);
    idle(2);
    check("plan_divu", {hi_reg, lo_reg}, 64'h0000_0002_2AAA_AAAA);
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    idle(2);
    check("plan_div_ovf", {hi_reg, lo_reg}, 64'h0000_0000_8000_0000);
    send(OP_DIVU, 32'd5, 32'd0, 0, 1'b0);
    idle(2);
    check("plan_div0", {hi_reg, lo_reg}, 64'h0000_0005_FFFF_FFFF);

    send(OP_DIV, 32'd100, 32'd7, 10, 1'b0);
    send(OP_MULT, 32'd5, 32'd6, 5, 1'b1);

    send(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0);
    send(OP_MTLO, 32'h0000_00AB, 32'd0, 0, 1'b0);
    idle(2);
    check("plan_fwd_lo", {32'd0, lo_reg}, 64'h0000_0000_0000_00AB);

    @(negedge clk);
    op_valid = 1'b1;
    op       = OP_DIV;
    flush    = 1'b1;
    #1;
    check("flush_idle_stall", {63'd0, stall}, 64'd0);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      send(ro, pick(), pick(), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 32) : 0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Sequences every write to the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the EX stage. Accepts one op per request, runs 32-step iterative multiply/divide, stalls the pipeline while busy, and drives the single write port of the hilo register.
- The hilo register has one write-enable for both halves, so this block merges MTHI/MTLO data with the current other half.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER_W, 5, iteration counter width; log2(XLEN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  EX holds an HI/LO-writing op
- op  in  3  op code, encodings in shared defines
- src_a  in  XLEN  rs value; dividend / multiplicand / MT data
- src_b  in  XLEN  rt value; divisor / multiplier
- flush  in  1  kill the in-flight op (exception)
- hi_rdata  in  XLEN  current HI from the hilo register
- lo_rdata  in  XLEN  current LO from the hilo register
- stall  out  1  hold EX and earlier stages; combinational
- hilo_we  out  1  write pulse to hilo, registered
- hilo_hi_wdata  out  XLEN  HI write data, registered
- hilo_lo_wdata  out  XLEN  LO write data, registered

Behaviour:
- Op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; others are treated as NOP.
- States: IDLE, MUL, DIV. Reset gives state=IDLE, count=0, stall=0, hilo_we=0, both wdata=0. A reset mid-operation aborts the op with no write.
- Accept: only in IDLE, when op_valid=1, flush=0 and op is not NOP. The accept cycle is cycle 0.
- MTHI/MTLO:
  - No stall. hilo_we=1 in cycle 1.
  - MTHI writes {src_a, cur_lo}; MTLO writes {cur_hi, src_a}.
  - cur_hi/cur_lo are the pending hilo_*_wdata when hilo_we=1 this cycle, otherwise hi_rdata/lo_rdata. This internal forwarding makes back-to-back MT ops correct.
- MUL/DIV:
  - Cycle 0: latch operand magnitudes and result signs (signed ops only), set count=0, go to MUL or DIV.
  - Cycles 1..32 iterate one bit per cycle. Multiply uses shift-add into a 64-bit accumulator. Divide uses restoring shift-subtract, producing quotient and remainder.
  - stall=1 for cycles 0..31. stall=0 in cycle 32 (count==31), the final iteration; the op leaves EX and state returns to IDLE.
  - hilo_we=1 in cycle 33.
  - MULT/MULTU: {HI,LO}=64-bit product. For signed ops, negate the product when the operand signs differ.
  - DIV/DIVU: LO=quotient, HI=remainder. For signed ops, the quotient is negative when signs differ, and the remainder takes the dividend's sign. Magnitudes are computed on 33 bits so 0x80000000 works correctly.
  - Divide by zero: fixed 32-cycle latency; result HI=src_a as latched, LO=0xFFFFFFFF, for both signed and unsigned.
- A new op may be accepted in the same cycle that the previous op's hilo_we pulses.
- flush:
  - In MUL/DIV: go to IDLE next cycle, no write, stall=0 in the flush cycle.
  - In IDLE with op_valid: no accept.
  - Never cancels a hilo_we that is already registered.
- stall = (IDLE & op_valid & ~flush & op∈{MULT..DIVU}) | ((MUL|DIV) & count!=31 & ~flush).
- op_valid and op are ignored while state is MUL or DIV.

Optional Feature:
- Macro: HILO_MDU_FAST_MUL_EN.
- When defined:
  - MULT/MULTU use a single combinational 33x33 signed multiply in the MUL state.
  - stall=1 only in cycle 0; MUL lasts one cycle with stall=0; hilo_we=1 in cycle 2.
  - DIV is unchanged.
- When undefined: 32-cycle iterative multiplier as above, and no hardware multiplier is inferred.

Decomposition:
- Shared include hilo_mdu_defs.vh holds:
  - the op code `defines and the op width (3);
  - the state encodings;
  - the divide-by-zero LO constant 0xFFFFFFFF.
- One sub-module, mdu_div_iter: the restoring divider datapath with inputs load/step, magnitudes in, quotient and remainder out. The multiplier stays inline.

Test Plan:
- MTHI 0x11111111, then MTLO 0x22222222 on the next cycle, with HI/LO initially 0 -> writes {0x11111111,0x00000000}, then {0x11111111,0x22222222}; stall never asserted.
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> stall high cycles 0..31; cycle 33 hilo_we=1 with HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0x80000000/3 -> LO=0x2AAAAAAA, HI=0x00000002. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> at cycle 33 HI=0x00000005, LO=0xFFFFFFFF.
- DIV started, flush at cycle 10 -> IDLE at cycle 11, no hilo_we, stall=0 from cycle 10. rst at cycle 5 of a MULT -> all outputs 0 next cycle, no write.
- MULT then MTLO 0xAB presented in cycle 33 -> MULT result written in cycle 33; MTLO writes {MULT HI, 0x000000AB} in cycle 34 via forwarding.
